// File: rtl/kore_pkg.sv
// Shared types and default widths for the kore register-bank arbiter.
package kore_pkg;

    localparam int unsigned KORE_AW = 5;
    localparam int unsigned KORE_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } kore_state_e;

endpackage : kore_pkg

// File: rtl/kore_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module kore_rr_arb #(
    parameter int unsigned NPORT = 2,
    parameter int unsigned PW    = 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NPORT-1:0] gnt_c,
    output logic             valid_c
);

    int unsigned idx;

    always_comb begin
        gnt_c   = '0;
        valid_c = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            idx = (32'(ptr) + i) % NPORT;
            if (!valid_c && req[idx]) begin
                gnt_c[idx] = 1'b1;
                valid_c    = 1'b1;
            end
        end
    end

endmodule : kore_rr_arb

// File: rtl/kore_regbank_arb.sv
// Arbitrates NPORT requesters onto one register bank, one access per 3 cycles.
module kore_regbank_arb
    import kore_pkg::*;
#(
    parameter int unsigned NPORT = 2,
    parameter int unsigned AW    = KORE_AW,
    parameter int unsigned DW    = KORE_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPORT-1:0]    req_i,
    input  logic [NPORT-1:0]    we_i,
    input  logic [NPORT*AW-1:0] addr_i,
    input  logic [NPORT*DW-1:0] wdata_i,
    output logic [NPORT-1:0]    gnt_o,
    output logic [NPORT-1:0]    done_o,
    output logic [DW-1:0]       rdata_o,
    output logic                busy_o,
    output logic [AW-1:0]       reg_sel_o,
    output logic [DW-1:0]       din_o,
    output logic                wt_en_o,
    input  logic [DW-1:0]       dout_i
);

    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    kore_state_e         state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                we_q, we_d;
    logic [NPORT-1:0]    gnt_d, done_d;
    logic [DW-1:0]       rdata_d, din_d;
    logic [AW-1:0]       reg_sel_d;
    logic                wt_en_d, busy_d;

    logic [NPORT-1:0]    arb_gnt_c;
    logic                arb_valid_c;
    logic                sel_we_c;
    logic [AW-1:0]       sel_addr_c;
    logic [DW-1:0]       sel_wdata_c;
    logic [PW-1:0]       sel_ptr_c;

    kore_rr_arb #(
        .NPORT (NPORT),
        .PW    (PW)
    ) u_rr_arb (
        .req     (req_i),
        .ptr     (ptr_q),
        .gnt_c   (arb_gnt_c),
        .valid_c (arb_valid_c)
    );

    // Mux the winning port's payload and the pointer value that follows it.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        sel_ptr_c   = ptr_q;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (arb_gnt_c[i]) begin
                sel_we_c    = we_i[i];
                sel_addr_c  = addr_i[i*AW +: AW];
                sel_wdata_c = wdata_i[i*DW +: DW];
                sel_ptr_c   = PW'((i + 1) % NPORT);
            end
        end
    end

    // reg_sel/din double as the latched address and write data.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        we_d      = we_q;
        gnt_d     = '0;
        done_d    = '0;
        wt_en_d   = 1'b0;
        reg_sel_d = reg_sel_o;
        din_d     = din_o;
        rdata_d   = rdata_o;
        unique case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    state_d   = ACCESS;
                    ptr_d     = sel_ptr_c;
                    we_d      = sel_we_c;
                    gnt_d     = arb_gnt_c;
                    wt_en_d   = sel_we_c;
                    reg_sel_d = sel_addr_c;
                    din_d     = sel_wdata_c;
                end
            end
            ACCESS: begin
                state_d = RESP;
                done_d  = gnt_o;
                rdata_d = we_q ? din_o : dout_i;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            gnt_o     <= '0;
            done_o    <= '0;
            wt_en_o   <= 1'b0;
            reg_sel_o <= '0;
            din_o     <= '0;
            rdata_o   <= '0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            gnt_o     <= gnt_d;
            done_o    <= done_d;
            wt_en_o   <= wt_en_d;
            reg_sel_o <= reg_sel_d;
            din_o     <= din_d;
            rdata_o   <= rdata_d;
            busy_o    <= busy_d;
        end
    end

endmodule : kore_regbank_arb

// File: tb/tb_kore_regbank_arb.sv
// Scoreboard bench for kore_regbank_arb with a behavioural 32-entry register bank.
module tb_kore_regbank_arb;

    localparam int unsigned NPORT = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic                clk;
    logic                rst_n;
    logic [NPORT-1:0]    req_i;
    logic [NPORT-1:0]    we_i;
    logic [NPORT*AW-1:0] addr_i;
    logic [NPORT*DW-1:0] wdata_i;
    logic [NPORT-1:0]    gnt_o;
    logic [NPORT-1:0]    done_o;
    logic [DW-1:0]       rdata_o;
    logic                busy_o;
    logic [AW-1:0]       reg_sel_o;
    logic [DW-1:0]       din_o;
    logic                wt_en_o;
    logic [DW-1:0]       dout_i;

    kore_regbank_arb #(.NPORT(NPORT), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .rdata_o   (rdata_o),
        .busy_o    (busy_o),
        .reg_sel_o (reg_sel_o),
        .din_o     (din_o),
        .wt_en_o   (wt_en_o),
        .dout_i    (dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: not reset, so an aborted write must leave it untouched.
    logic [DW-1:0] bank [32] = '{default: '0};
    always @(posedge clk) if (wt_en_o) bank[reg_sel_o] <= din_o;
    assign dout_i = bank[reg_sel_o];

    typedef struct {
        int          port;
        logic [31:0] data;
    } done_exp_t;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_exp_t;

    int        gnt_q[$];
    done_exp_t done_q[$];
    wr_exp_t   wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int prev_done_cyc = 0;
    int last_done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string nm, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected no event (t=%0t)", nm, act, $time);
    endfunction

    // Monitor: pops and compares whenever the DUT presents gnt, done or wt_en.
    always @(negedge clk) begin
        if (gnt_o != '0) begin
            if (gnt_q.size() == 0) unexpected("gnt_unexpected", 64'(gnt_o));
            else chk("gnt", 64'(gnt_o), 64'(1) << gnt_q.pop_front());
        end
        if (done_o != '0) begin
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (done_q.size() == 0) unexpected("done_unexpected", 64'(done_o));
            else begin
                done_exp_t e;
                e = done_q.pop_front();
                chk("done_port", 64'(done_o), 64'(1) << e.port);
                chk("rdata", 64'(rdata_o), 64'(e.data));
            end
        end
        if (wt_en_o) begin
            if (wr_q.size() == 0) unexpected("wt_en_unexpected", 64'(reg_sel_o));
            else begin
                wr_exp_t w;
                w = wr_q.pop_front();
                chk("wr_sel", 64'(reg_sel_o), 64'(w.sel));
                chk("wr_data", 64'(din_o), 64'(w.data));
            end
        end
    end

    task automatic set_port(input int p, input logic we, input logic [4:0] a, input logic [31:0] d);
        we_i[p]            = we;
        addr_i[p*AW +: AW] = a;
        wdata_i[p*DW +: DW] = d;
    endtask

    task automatic push_done(input int p, input logic [31:0] d);
        done_exp_t e;
        e.port = p;
        e.data = d;
        done_q.push_back(e);
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_exp_t w;
        w.sel  = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    // Assert reset, check the reset state, release just after a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        req_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_wt_en", 64'(wt_en_o), 64'(0));
        chk("rst_reg_sel", 64'(reg_sel_o), 64'(0));
        chk("rst_din", 64'(din_o), 64'(0));
        chk("rst_rdata", 64'(rdata_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        #1 rst_n = 1'b1;
    endtask

    // Raise req for the ports in mask, dropping each as its grant is seen.
    task automatic run_reqs(input logic [NPORT-1:0] mask);
        int budget;
        req_i  = mask;
        budget = 0;
        while (req_i != '0 && budget < 40) begin
            @(negedge clk);
            #1;
            req_i = req_i & ~gnt_o;
            budget++;
        end
        if (req_i != '0) unexpected("grant_timeout", 64'(req_i));
        req_i = '0;
        budget = 0;
        while (busy_o && budget < 10) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (busy_o) unexpected("idle_timeout", 64'(busy_o));
    endtask

    initial begin
        rst_n   = 1'b0;
        req_i   = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        do_reset();

        // Write then read back reg 3 from port 0.
        set_port(0, 1'b1, 5'd3, 32'hDEADBEEF);
        gnt_q.push_back(0);
        push_wr(5'd3, 32'hDEADBEEF);
        push_done(0, 32'hDEADBEEF);
        run_reqs(2'b01);
        chk("hold_reg_sel", 64'(reg_sel_o), 64'(3));
        chk("hold_din", 64'(din_o), 64'hDEADBEEF);
        chk("idle_wt_en", 64'(wt_en_o), 64'(0));
        set_port(0, 1'b0, 5'd3, 32'h0);
        gnt_q.push_back(0);
        push_done(0, 32'hDEADBEEF);
        run_reqs(2'b01);

        // Simultaneous reads after reset: port 0 first, done pulses 3 cycles apart.
        do_reset();
        set_port(0, 1'b0, 5'd3, 32'h0);
        set_port(1, 1'b0, 5'd5, 32'h0);
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        push_done(0, 32'hDEADBEEF);
        push_done(1, 32'h0);
        run_reqs(2'b11);
        chk("done_spacing", 64'(last_done_cyc - prev_done_cyc), 64'(3));

        // Both ports held for 12 cycles: grants alternate 0,1,0,1.
        do_reset();
        set_port(0, 1'b0, 5'd3, 32'h0);
        set_port(1, 1'b0, 5'd31, 32'h0);
        for (int i = 0; i < 2; i++) begin
            gnt_q.push_back(0);
            gnt_q.push_back(1);
            push_done(0, 32'hDEADBEEF);
            push_done(1, 32'h0);
        end
        req_i = 2'b11;
        repeat (12) @(negedge clk);
        #1 req_i = '0;
        repeat (4) @(negedge clk);
        chk("rr_idle_busy", 64'(busy_o), 64'(0));

        // Reset during ACCESS of a write to reg 7 aborts it.
        do_reset();
        set_port(0, 1'b1, 5'd7, 32'h12345678);
        gnt_q.push_back(0);
        push_wr(5'd7, 32'h12345678);
        req_i = 2'b01;
        for (int i = 0; i < 10 && gnt_o[0] !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_in_access", 64'(gnt_o), 64'(1));
        do_reset();
        set_port(0, 1'b0, 5'd7, 32'h0);
        gnt_q.push_back(0);
        push_done(0, 32'h0);
        run_reqs(2'b01);

        // Single read of reg 31: cycle-exact latency and busy width.
        do_reset();
        set_port(0, 1'b0, 5'd31, 32'h0);
        gnt_q.push_back(0);
        push_done(0, 32'h0);
        chk("lat_busy0", 64'(busy_o), 64'(0));
        req_i = 2'b01;
        @(negedge clk);
        #1;
        chk("lat_gnt_c1", 64'(gnt_o), 64'(1));
        chk("lat_busy_c1", 64'(busy_o), 64'(1));
        req_i = '0;
        @(negedge clk);
        #1;
        chk("lat_done_c2", 64'(done_o), 64'(1));
        chk("lat_busy_c2", 64'(busy_o), 64'(1));
        chk("lat_rdata_c2", 64'(rdata_o), 64'(0));
        @(negedge clk);
        #1;
        chk("lat_busy_c3", 64'(busy_o), 64'(0));
        chk("lat_done_c3", 64'(done_o), 64'(0));

        repeat (5) @(negedge clk);
        chk("gnt_q_empty", 64'(gnt_q.size()), 64'(0));
        chk("done_q_empty", 64'(done_q.size()), 64'(0));
        chk("wr_q_empty", 64'(wr_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_kore_regbank_arb

// File: doc/kore_regbank_arb.md
KORE_REGBANK_ARB -- requirements
Module: kore_regbank_arb

Interface
REQ-001 Parameter NPORT, default 2, meaning number of requester ports (2..8).
REQ-002 Parameter AW, default 5, meaning register-select width.
REQ-003 Parameter DW, default 32, meaning data width.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  NPORT  per-port access request, level.
REQ-007 we_i  input  NPORT  per-port write (1) / read (0) select.
REQ-008 addr_i  input  NPORT*AW  per-port register select; port k at bits [k*AW +: AW].
REQ-009 wdata_i  input  NPORT*DW  per-port write data; port k at bits [k*DW +: DW].
REQ-010 gnt_o  output  NPORT  one-hot grant pulse.
REQ-011 done_o  output  NPORT  one-hot completion pulse.
REQ-012 rdata_o  output  DW  read data, valid while done_o is nonzero.
REQ-013 busy_o  output  1  high whenever the state is not IDLE.
REQ-014 reg_sel_o  output  AW  register select to the register bank.
REQ-015 din_o  output  DW  write data to the register bank.
REQ-016 wt_en_o  output  1  write enable to the register bank.
REQ-017 dout_i  input  DW  combinational read data from the register bank for reg_sel_o.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP.
- IDLE to ACCESS when any req_i bit is high.
- ACCESS to RESP unconditionally.
- RESP to IDLE unconditionally.
REQ-019 req_i SHALL be sampled only in IDLE; requests in ACCESS or RESP are held off, not lost, while req_i stays high.
REQ-020 On the IDLE to ACCESS edge, the block SHALL select a winner by round-robin.
- Search starts at the priority pointer and proceeds upward with wrap-around.
- The winner's we/addr/wdata SHALL be latched at this edge.
REQ-021 After a grant to port k, the priority pointer SHALL become (k+1) mod NPORT.
REQ-022 gnt_o[winner] SHALL be high for exactly the ACCESS cycle; the requester may change its inputs from the following cycle.
REQ-023 In ACCESS, reg_sel_o and din_o SHALL carry the latched addr and wdata, and wt_en_o SHALL equal the latched we.
REQ-024 Outside ACCESS, wt_en_o SHALL be 0; reg_sel_o and din_o SHALL hold their last values.
REQ-025 At the end of ACCESS, rdata_o SHALL register dout_i for reads; for writes, rdata_o SHALL register the latched wdata.
REQ-026 done_o[winner] SHALL be high for exactly the RESP cycle.
REQ-027 Latency: a request sampled at edge N SHALL produce gnt in cycle N+1 and done in cycle N+2; peak throughput is one transaction per 3 cycles.
REQ-028 A requester holding req_i high through done_o SHALL be treated as issuing a new request.
REQ-029 Only one bank access SHALL be in flight at a time; at most one wt_en_o pulse SHALL occur per transaction.
REQ-030 A write followed by a read of the same register SHALL return the written data.

Reset
REQ-031 While rst_n is low, the following SHALL hold:
- state = IDLE, priority pointer = 0;
- gnt_o, done_o and wt_en_o = 0;
- reg_sel_o, din_o and rdata_o = 0;
- busy_o = 0.
REQ-032 Reset asserted in ACCESS or RESP SHALL abort the transaction: no done_o, no further wt_en_o.
REQ-033 The first sampling after reset release SHALL occur at the first rising edge with rst_n high.

Structure
REQ-034 Shared package kore_pkg SHALL hold the FSM state enum and the AW/DW default constants.
REQ-035 Round-robin selection SHALL be a sub-module kore_rr_arb; inputs are req and pointer, outputs are a one-hot grant and a valid flag.

Verification
REQ-036 Port0 writes 0xDEADBEEF to reg 3, then port0 reads reg 3 -> wt_en_o pulses 1 cycle with reg_sel_o=3; the read's done_o[0] comes with rdata_o=0xDEADBEEF.
REQ-037 Port0 and port1 request reads in the same cycle after reset -> port0 is granted first and port1 is granted in the next transaction; their done_o pulses are 3 cycles apart.
REQ-038 Both ports hold req_i high for 12 cycles -> grants alternate 0,1,0,1; no port is granted twice in a row.
REQ-039 rst_n pulled low in ACCESS of a write of 0x12345678 to reg 7 -> no done_o; a later read of reg 7 returns 0.
REQ-040 A single read of reg 31 after reset -> gnt_o[0] in cycle 1, done_o[0] in cycle 2, rdata_o=0, busy_o high for exactly 2 cycles.
